// File: rtl/mux_4_1_arbiter_pkg.sv
// mux_arb_pkg: shared constants and FSM encoding for the 4:1 mux arbiter.
package mux_arb_pkg;
    localparam int IDX_W = 2;
    localparam int N_REQ = 4;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
endpackage

// File: rtl/mux_4_1_arbiter_if.sv
// mux_4_1_arbiter_if: requester lines plus grant and mux-select outputs.
interface mux_4_1_arbiter_if;
    import mux_arb_pkg::*;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic s0;
    logic s1;
    logic valid;
    logic [IDX_W-1:0] owner;
    modport master(output req, input gnt, s0, s1, valid, owner);
    modport slave(input req, output gnt, s0, s1, valid, owner);
endinterface

// File: rtl/mux_4_1_arbiter_rr_pick4.sv
// rr_pick4: first asserted request after index last, wrapping 3 to 0.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick,
    output logic             any
);
    // Scan farthest offset first so the nearest requester after last wins.
    always_comb begin
        pick = last;
        for (int i = N_REQ; i >= 1; i--)
            if (req[last + IDX_W'(i)]) pick = last + IDX_W'(i);
    end
    assign any = |req;
endmodule

// File: rtl/mux_4_1_arbiter.sv
// mux_4_1_arbiter: round-robin owner of the shared 4:1 mux with break-before-make gap and hold timeout.
module mux_4_1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input logic               clk,
    input logic               rst,
    mux_4_1_arbiter_if.slave  bus
);
    logic [1:0]       state, state_n;
    logic [N_REQ-1:0] gnt, gnt_n;
    logic [IDX_W-1:0] sel, sel_n, last, last_n, pick;
    logic [HOLD_W-1:0] cnt, cnt_n;
    logic any, arb, rel;
    rr_pick4 u_pick (.req(bus.req), .last(last), .pick(pick), .any(any));
    // sel and last only move at an arbitration point, so select is stable while valid.
    always_comb begin
        arb     = (state == IDLE || state == GAP) && any;
        rel     = state == GRANT && (!bus.req[sel] || cnt == HOLD_W'(MAX_HOLD - 1));
        state_n = arb ? GRANT : rel ? GAP : state == GAP ? IDLE : state;
        gnt_n   = arb ? N_REQ'(1) << pick : rel ? '0 : gnt;
        sel_n   = arb ? pick : sel;
        last_n  = arb ? pick : last;
        cnt_n   = arb ? '0 : state == GRANT ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            last  <= IDX_W'(N_REQ - 1);
            cnt   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end
    assign bus.gnt   = gnt;
    assign bus.valid = |gnt;
    assign bus.owner = sel;
    assign bus.s1    = sel[1];
    assign bus.s0    = sel[0];
endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// tb_mux_4_1_arbiter: directed scenarios plus random requests against an owner/hold-count model.
module tb_mux_4_1_arbiter;
    import mux_arb_pkg::*;
    localparam int MAX_HOLD = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int m_own = -1, m_held = 0, m_last = 3, m_sel = 0, m_p;
    mux_4_1_arbiter_if bus();
    mux_4_1_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // Model: who owns the mux and for how long; a release edge never also grants.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_own = -1; m_held = 0; m_last = 3; m_sel = 0;
        end else if (m_own >= 0) begin
            m_held++;
            if (!bus.req[m_own] || m_held == MAX_HOLD) m_own = -1;
        end else begin
            m_p = -1;
            for (int k = 1; k <= 4; k++)
                if (m_p < 0 && bus.req[(m_last + k) % 4]) m_p = (m_last + k) % 4;
            if (m_p >= 0) begin
                m_own = m_p; m_sel = m_p; m_last = m_p; m_held = 0;
            end
        end
    end

    function automatic logic [3:0] exp_gnt();
        return (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
    endfunction

    task automatic do_reset;
        bus.req = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        bus.req = 4'hf;
        rst = 1'b1;
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        tests++; if ({bus.s1, bus.s0} !== 2'b00) begin fails++; $display("FAIL reset_sel: got %b expected 00", {bus.s1, bus.s0}); end
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        tests++; if (bus.owner !== 2'd0) begin fails++; $display("FAIL reset_owner: got %0d expected 0", bus.owner); end
        bus.req = '0;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL reset_idle_gnt: got %b expected 0000", bus.gnt); end
    endtask

    task automatic test_single;
        do_reset;
        bus.req = 4'b0100;
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt: got %b expected 0100", bus.gnt); end
        tests++; if ({bus.s1, bus.s0} !== 2'b10) begin fails++; $display("FAIL single_sel: got %b expected 10", {bus.s1, bus.s0}); end
        tests++; if (bus.valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", bus.valid); end
        repeat (2) begin
            @(negedge clk);
            tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL single_hold: got %b expected 0100", bus.gnt); end
        end
        bus.req = '0;
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL single_drop: got %b expected 0000", bus.gnt); end
        tests++; if ({bus.s1, bus.s0} !== 2'b10) begin fails++; $display("FAIL single_gap_sel: got %b expected 10", {bus.s1, bus.s0}); end
        @(negedge clk);
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL single_idle: got %0d expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_round_robin;
        int order[$];
        int run = 0, gaps = 0;
        logic pv = 1'b0;
        logic [1:0] po = 2'd0;
        do_reset;
        bus.req = 4'hf;
        for (int cyc = 0; cyc < 40 && order.size() < 5; cyc++) begin
            @(negedge clk);
            if (bus.valid) begin
                if (!pv) begin
                    if (order.size() > 0) begin
                        tests++; if (gaps != 1) begin fails++; $display("FAIL rr_gap: got %0d dead cycles expected 1", gaps); end
                    end
                    order.push_back(int'(bus.owner));
                    run = 0;
                end else begin
                    tests++; if (bus.owner !== po) begin fails++; $display("FAIL rr_sel_stable: got %0d expected %0d", bus.owner, po); end
                end
                run++;
                po = bus.owner;
                if (run == 2) bus.req[bus.owner] = 1'b0;
                gaps = 0;
            end else begin
                gaps++;
                bus.req = 4'hf;
            end
            pv = bus.valid;
        end
        tests++; if (order.size() != 5) begin fails++; $display("FAIL rr_count: got %0d grants expected 5", order.size()); end
        foreach (order[i]) begin
            tests++; if (order[i] != i % 4) begin fails++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % 4); end
        end
        bus.req = '0;
    endtask

    task automatic test_timeout;
        logic [3:0] e;
        do_reset;
        bus.req = 4'b0011;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            e = (k % 5 == 4) ? 4'b0000 : ((k / 5) % 2 == 0) ? 4'b0001 : 4'b0010;
            tests++; if (bus.gnt !== e) begin fails++; $display("FAIL timeout[%0d]: got %b expected %b", k, bus.gnt, e); end
        end
        bus.req = '0;
    endtask

    task automatic test_simultaneous;
        do_reset;
        bus.req = 4'b0101;
        for (int k = 0; k < MAX_HOLD; k++) begin
            @(negedge clk);
            tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL simul_hold[%0d]: got %b expected 0001", k, bus.gnt); end
            if (k == MAX_HOLD - 1) bus.req[0] = 1'b0;
        end
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL simul_gap: got %b expected 0000", bus.gnt); end
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL simul_next: got %b expected 0100", bus.gnt); end
        bus.req = 4'b0011;
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL simul_gap2: got %b expected 0000", bus.gnt); end
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL simul_after: got %b expected 0001", bus.gnt); end
        bus.req = '0;
    endtask

    task automatic test_reset_mid;
        do_reset;
        bus.req = 4'b1000;
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b1000) begin fails++; $display("FAIL rmid_grant: got %b expected 1000", bus.gnt); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL rmid_gnt: got %b expected 0000", bus.gnt); end
        tests++; if ({bus.s1, bus.s0} !== 2'b00) begin fails++; $display("FAIL rmid_sel: got %b expected 00", {bus.s1, bus.s0}); end
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b expected 0", bus.valid); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b1000) begin fails++; $display("FAIL rmid_regrant: got %b expected 1000", bus.gnt); end
        tests++; if (bus.owner !== 2'd3) begin fails++; $display("FAIL rmid_owner: got %0d expected 3", bus.owner); end
        bus.req = '0;
    endtask

    task automatic test_late;
        do_reset;
        bus.req = 4'b0010;
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL late_b: got %b expected 0010", bus.gnt); end
        bus.req = 4'b0110;
        repeat (2) begin
            @(negedge clk);
            tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL late_b_keeps: got %b expected 0010", bus.gnt); end
        end
        bus.req = 4'b0100;
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL late_gap: got %b expected 0000", bus.gnt); end
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL late_c: got %b expected 0100", bus.gnt); end
        bus.req = '0;
    endtask

    task automatic test_random;
        do_reset;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            tests++; if (bus.gnt !== exp_gnt()) begin fails++; $display("FAIL rand_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_gnt()); end
            tests++; if (bus.owner !== 2'(m_sel)) begin fails++; $display("FAIL rand_owner[%0d]: got %0d expected %0d", k, bus.owner, m_sel); end
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
            if (k == 200) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        bus.req = '0;
    endtask

    initial begin
        bus.req = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_simultaneous;
        test_reset_mid;
        test_late;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
